// File: rtl/dmem_responder.sv
// Data-cache memory responder: word RAM plus LED/switch/cycle MMIO window, 3-state handshake FSM.
// Optional cycle counter enabled by defining DMEM_CYCLE_COUNTER_EN.
module dmem_responder #(
  parameter int          ADDR_BITS = 14,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_err,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out
);

  localparam int WORDS = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RWAIT = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   ready_q, ready_d;
  logic                   err_q, err_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [15:0]            led_q, led_d;
  logic [15:0]            sw_meta_q, sw_sync_q;
  logic [31:0]            ram_rd_q;
  logic [31:0]            ram_mem [WORDS];

  logic                   is_ram_s;
  logic                   is_mmio_s;
  logic [ADDR_BITS-1:0]   word_idx_s;
  logic [1:0]             mmio_off_s;
  logic                   ram_we_s;
  logic                   ram_re_s;
  logic                   cyc_clr_s;
  logic [31:0]            cycle_s;
  logic [31:0]            mmio_rdata_s;

  // Register file view of the MMIO window as seen by a read.
  function automatic logic [31:0] mmio_read(input logic [1:0]  off,
                                            input logic [15:0] led,
                                            input logic [15:0] sw,
                                            input logic [31:0] cyc);
    case (off)
      2'd0:    mmio_read = {16'h0000, led};
      2'd1:    mmio_read = {16'h0000, sw};
      2'd2:    mmio_read = cyc;
      2'd3:    mmio_read = 32'h0000_0000;
      default: mmio_read = 32'h0000_0000;
    endcase
  endfunction

  // Address decode of the current request.
  always_comb begin
    is_ram_s     = ((mem_addr >> (ADDR_BITS + 2)) == 32'd0);
    is_mmio_s    = (mem_addr[31:4] == MMIO_BASE[31:4]);
    word_idx_s   = mem_addr[ADDR_BITS+1:2];
    mmio_off_s   = mem_addr[3:2];
    mmio_rdata_s = mmio_read(mmio_off_s, led_q, sw_sync_q, cycle_s);
  end

  // FSM next state and datapath next values.
  always_comb begin
    state_d   = state_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    led_d     = led_q;
    ram_we_s  = 1'b0;
    ram_re_s  = 1'b0;
    cyc_clr_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_req) begin
          if (is_ram_s) begin
            if (mem_we) begin
              ram_we_s = 1'b1;
              state_d  = ST_RESP;
              ready_d  = 1'b1;
            end else begin
              ram_re_s = 1'b1;
              state_d  = ST_RWAIT;
            end
          end else if (is_mmio_s) begin
            state_d = ST_RESP;
            ready_d = 1'b1;
            if (mem_we) begin
              if (mmio_off_s == 2'd0) begin
                led_d = mem_wdata[15:0];
              end else if (mmio_off_s == 2'd2) begin
                cyc_clr_s = 1'b1;
              end else begin
                led_d = led_q;
              end
            end else begin
              rdata_d = mmio_rdata_s;
            end
          end else begin
            state_d = ST_RESP;
            ready_d = 1'b1;
            err_d   = 1'b1;
            if (mem_we) begin
              rdata_d = rdata_q;
            end else begin
              rdata_d = 32'h0000_0000;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RWAIT: begin
        rdata_d = ram_rd_q;
        ready_d = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0000_0000;
      led_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      led_q   <= led_d;
    end
  end

  // Two-flop synchronizer for the asynchronous switch inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta_q <= 16'h0000;
      sw_sync_q <= 16'h0000;
    end else begin
      sw_meta_q <= sw_in;
      sw_sync_q <= sw_meta_q;
    end
  end

  // Synchronous-read data RAM; contents deliberately not reset, writes blocked while in reset.
  always_ff @(posedge clk) begin
    if (ram_we_s && reset) begin
      ram_mem[word_idx_s] <= mem_wdata;
    end
    if (ram_re_s && reset) begin
      ram_rd_q <= ram_mem[word_idx_s];
    end
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycle_q;

  // Free-running cycle counter, cleared by any write to the CYCLE register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q <= 32'h0000_0000;
    end else if (cyc_clr_s) begin
      cycle_q <= 32'h0000_0000;
    end else begin
      cycle_q <= cycle_q + 32'd1;
    end
  end

  assign cycle_s = cycle_q;
`else
  logic unused_cyc_clr_s;

  assign unused_cyc_clr_s = cyc_clr_s;
  assign cycle_s          = 32'h0000_0000;
`endif

  assign mem_ready = ready_q;
  assign mem_err   = err_q;
  assign mem_rdata = rdata_q;
  assign led_out   = led_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic
// against a word-level reference model (RAM array, LED/switch/counter state).
module tb_dmem_responder;

  localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic [15:0] sw_in = 16'h0;
  logic [15:0] led_out;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  logic [31:0] ram_m [int];
  logic [15:0] led_m;
  logic [15:0] sw_m;
  logic [31:0] rdata_m;
  int          clr_edge;

  dmem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .mem_err   (mem_err),
    .sw_in     (sw_in),
    .led_out   (led_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Issue one request from a negedge; returns completion info and ends on a negedge.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat,
                        output logic [15:0] led1, output int acc, output logic pulse_ok);
    mem_req   = 1'b1;
    mem_we    = we;
    mem_addr  = addr;
    mem_wdata = wd;
    @(posedge clk);
    #1;
    acc     = edge_cnt;
    mem_req = 1'b0;
    lat = 0; rd = 32'h0; er = 1'b0; led1 = 16'h0; pulse_ok = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) led1 = led_out;
      if (mem_ready) begin
        lat = i;
        rd  = mem_rdata;
        er  = mem_err;
        break;
      end
    end
    if (lat != 0) begin
      @(negedge clk);
      pulse_ok = !mem_ready && !mem_err;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", mem_ready); end
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", mem_err); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", mem_rdata); end
    checks++; if (led_out !== 16'h0) begin errors++; $display("FAIL rst_led: got %h want 0", led_out); end
    reset = 1'b1;
    led_m = 16'h0; rdata_m = 32'h0; sw_m = 16'h0;
    @(negedge clk);
  endtask

  task automatic test_ram_rw();
    logic [31:0] rd; logic er; int lat; logic [15:0] l1; int acc; logic pok;
    do_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rd, er, lat, l1, acc, pok);
    ram_m[4] = 32'hDEAD_BEEF;
    checks++; if (lat !== 1) begin errors++; $display("FAIL ram_wr_lat: got %0d want 1", lat); end
    checks++; if (pok !== 1'b1) begin errors++; $display("FAIL ram_wr_pulse: got %b want 1", pok); end
    checks++; if (rd !== rdata_m) begin errors++; $display("FAIL ram_wr_rdata_hold: got %h want %h", rd, rdata_m); end
    do_txn(1'b0, 32'h0000_0013, 32'h0, rd, er, lat, l1, acc, pok);
    rdata_m = 32'hDEAD_BEEF;
    checks++; if (lat !== 2) begin errors++; $display("FAIL ram_rd_lat: got %0d want 2", lat); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rd_data: got %h want deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL ram_rd_err: got %b want 0", er); end
  endtask

  task automatic test_led();
    logic [31:0] rd; logic er; int lat; logic [15:0] l1; int acc; logic pok;
    do_txn(1'b1, MMIO_BASE, 32'h1234_ABCD, rd, er, lat, l1, acc, pok);
    led_m = 16'hABCD;
    checks++; if (l1 !== 16'hABCD) begin errors++; $display("FAIL led_next: got %h want abcd", l1); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL led_wr_lat: got %0d want 1", lat); end
    do_txn(1'b0, MMIO_BASE, 32'h0, rd, er, lat, l1, acc, pok);
    rdata_m = 32'h0000_ABCD;
    checks++; if (rd !== 32'h0000_ABCD) begin errors++; $display("FAIL led_rd: got %h want 0000abcd", rd); end
  endtask

  task automatic test_switches();
    logic [31:0] rd; logic er; int lat; logic [15:0] l1; int acc; logic pok;
    sw_in = 16'h00F0; sw_m = 16'h00F0;
    repeat (3) @(negedge clk);
    do_txn(1'b0, MMIO_BASE + 32'd4, 32'h0, rd, er, lat, l1, acc, pok);
    rdata_m = 32'h0000_00F0;
    checks++; if (rd !== 32'h0000_00F0) begin errors++; $display("FAIL sw_rd: got %h want 000000f0", rd); end
    do_txn(1'b1, MMIO_BASE + 32'd4, 32'hFFFF_FFFF, rd, er, lat, l1, acc, pok);
    do_txn(1'b0, MMIO_BASE + 32'd4, 32'h0, rd, er, lat, l1, acc, pok);
    checks++; if (rd !== 32'h0000_00F0) begin errors++; $display("FAIL sw_ro: got %h want 000000f0", rd); end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd; logic er; int lat; logic [15:0] l1; int acc; logic pok;
    do_txn(1'b1, 32'h0000_0000, 32'h0BAD_F00D, rd, er, lat, l1, acc, pok);
    ram_m[0] = 32'h0BAD_F00D;
    do_txn(1'b0, 32'h8000_0000, 32'h0, rd, er, lat, l1, acc, pok);
    rdata_m = 32'h0;
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unm_rd_data: got %h want 0", rd); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL unm_rd_err: got %b want 1", er); end
    checks++; if (pok !== 1'b1) begin errors++; $display("FAIL unm_err_one_cycle: got %b want 1", pok); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL unm_rd_lat: got %0d want 1", lat); end
    do_txn(1'b1, 32'h8000_0000, 32'h5555_AAAA, rd, er, lat, l1, acc, pok);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL unm_wr_err: got %b want 1", er); end
    do_txn(1'b0, 32'h0000_0000, 32'h0, rd, er, lat, l1, acc, pok);
    rdata_m = 32'h0BAD_F00D;
    checks++; if (rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL unm_ram_intact: got %h want 0badf00d", rd); end
  endtask

  task automatic test_reset_rwait();
    logic [31:0] rd; logic er; int lat; logic [15:0] l1; int acc; logic pok;
    int pulses;
    do_txn(1'b1, 32'h0000_0020, 32'hCAFE_1234, rd, er, lat, l1, acc, pok);
    ram_m[8] = 32'hCAFE_1234;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0020;
    @(posedge clk);
    #1;
    mem_req = 1'b0;
    reset   = 1'b0;
    pulses  = 0;
    repeat (4) begin @(negedge clk); if (mem_ready) pulses++; end
    reset = 1'b1;
    repeat (2) begin @(negedge clk); if (mem_ready) pulses++; end
    led_m = 16'h0; rdata_m = 32'h0;
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rwait_rst_pulse: got %0d want 0", pulses); end
    checks++; if (led_out !== 16'h0) begin errors++; $display("FAIL rwait_rst_led: got %h want 0", led_out); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL rwait_rst_rdata: got %h want 0", mem_rdata); end
    do_txn(1'b0, 32'h0000_0020, 32'h0, rd, er, lat, l1, acc, pok);
    rdata_m = 32'hCAFE_1234;
    checks++; if (lat !== 2) begin errors++; $display("FAIL rwait_post_lat: got %0d want 2", lat); end
    checks++; if (rd !== 32'hCAFE_1234) begin errors++; $display("FAIL rwait_post_data: got %h want cafe1234", rd); end
  endtask

  task automatic test_counter();
    logic [31:0] rd; logic er; int lat; logic [15:0] l1; int acc_w; int acc_r; logic pok;
    logic [31:0] exp_v;
    do_txn(1'b1, MMIO_BASE + 32'd8, 32'h1234_5678, rd, er, lat, l1, acc_w, pok);
    clr_edge = acc_w;
    while (edge_cnt < acc_w + 9) @(negedge clk);
    do_txn(1'b0, MMIO_BASE + 32'd8, 32'h0, rd, er, lat, l1, acc_r, pok);
`ifdef DMEM_CYCLE_COUNTER_EN
    exp_v = 32'(acc_r - clr_edge - 1);
`else
    exp_v = 32'h0;
`endif
    rdata_m = exp_v;
    checks++; if (rd !== exp_v) begin errors++; $display("FAIL cycle_rd: got %0d want %0d", rd, exp_v); end
  endtask

  task automatic test_random();
    logic [31:0] rd; logic er; int lat; logic [15:0] l1; int acc; logic pok;
    logic [31:0] addr, wd, exp_rd; logic we; int kind, idx, off, exp_lat; logic exp_err;
    sw_in = 16'($urandom); sw_m = sw_in;
    repeat (3) @(negedge clk);
    do_txn(1'b1, MMIO_BASE + 32'd8, 32'h0, rd, er, lat, l1, acc, pok);
    clr_edge = acc;
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 3);
      we   = 1'($urandom_range(0, 1));
      wd   = $urandom;
      idx = 0; off = 0;
      if (kind == 0 || kind == 3) begin
        idx  = $urandom_range(0, 31);
        addr = 32'(idx << 2) | 32'($urandom_range(0, 3));
        if (!we && !ram_m.exists(idx)) we = 1'b1;
      end else if (kind == 1) begin
        off  = $urandom_range(0, 3);
        addr = MMIO_BASE | 32'(off << 2) | 32'($urandom_range(0, 3));
      end else begin
        addr = 32'h8000_0000 | ($urandom & 32'h7FFF_FFFF);
        if (addr[31:4] == MMIO_BASE[31:4]) addr = addr ^ 32'h0001_0000;
      end
      do_txn(we, addr, wd, rd, er, lat, l1, acc, pok);
      exp_err = (kind == 2);
      exp_lat = ((kind == 0 || kind == 3) && !we) ? 2 : 1;
      if (we) begin
        if (kind == 0 || kind == 3) ram_m[idx] = wd;
        else if (kind == 1 && off == 0) led_m = wd[15:0];
        else if (kind == 1 && off == 2) clr_edge = acc;
      end else begin
        if (kind == 0 || kind == 3) rdata_m = ram_m[idx];
        else if (kind == 2) rdata_m = 32'h0;
        else if (off == 0) rdata_m = {16'h0, led_m};
        else if (off == 1) rdata_m = {16'h0, sw_m};
`ifdef DMEM_CYCLE_COUNTER_EN
        else if (off == 2) rdata_m = 32'(acc - clr_edge - 1);
`endif
        else rdata_m = 32'h0;
      end
      exp_rd = rdata_m;
      checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rnd_lat[%0d] addr %h we %b: got %0d want %0d", n, addr, we, lat, exp_lat); end
      checks++; if (pok !== 1'b1) begin errors++; $display("FAIL rnd_pulse[%0d]: got %b want 1", n, pok); end
      checks++; if (er !== exp_err) begin errors++; $display("FAIL rnd_err[%0d] addr %h: got %b want %b", n, addr, er, exp_err); end
      checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rnd_rdata[%0d] addr %h we %b: got %h want %h", n, addr, we, rd, exp_rd); end
      checks++; if (l1 !== led_m) begin errors++; $display("FAIL rnd_led[%0d]: got %h want %h", n, l1, led_m); end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_ram_rw();
    test_led();
    test_switches();
    test_unmapped();
    test_reset_rwait();
    test_counter();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
